// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and the
// counter-width helper.
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor cell: difference and borrow for one bit position.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & (i_b | i_bin)) | (i_b & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - b_in), LSB first, one bit per clock.
// Optional comparison outputs lt/eq are enabled by defining SERIAL_SUB_CMP_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_CMP_EN
    output logic             lt,
    output logic             eq,
`endif
    output logic             overflow
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    full_subtractor u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_last    = (r_cnt == LAST);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // On the final RUN step r_brw is the borrow into the MSB, so overflow is
    // its XOR with the borrow out of the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_brw        <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_brw  <= b_in;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_brw  <= w_bout;
                    r_res  <= w_res_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff       <= w_res_nxt;
                        r_borrow_out <= w_bout;
                        r_overflow   <= r_brw ^ w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_CMP_EN
    logic r_lt;
    logic r_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lt <= 1'b0;
            r_eq <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_lt <= w_bout;
            r_eq <= (w_res_nxt == '0);
        end
    end

    assign lt = r_lt;
    assign eq = r_eq;
`endif

    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard testbench for serial_subtractor (WIDTH=8); lt/eq are also
// checked when SERIAL_SUB_CMP_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
`ifdef SERIAL_SUB_CMP_EN
    logic         lt;
    logic         eq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [W-1:0] held_diff = '0;
    exp_t q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUB_CMP_EN
        .lt         (lt),
        .eq         (eq),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            check("done_not_consecutive", prev_done, 1'b0);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("diff", diff, e.diff);
                check("borrow_out", borrow_out, e.bo);
                check("overflow", overflow, e.ov);
`ifdef SERIAL_SUB_CMP_EN
                check("lt", lt, e.bo);
                check("eq", eq, (e.diff == '0));
`endif
                held_diff = e.diff;
            end
        end
        prev_done = done;
    end

    // One operation; inj_at>0 pulses a second start mid-run, rst_at>0 aborts.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] ediff,
                          input logic ebo, input logic eov,
                          input int inj_at, input int rst_at);
        int cnt;
        int busy_cycles;
        logic [W-1:0] hold;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_; b_in = tbin; start = 1'b1;
        hold = held_diff;
        if (rst_at == 0) begin
            e.diff = ediff; e.bo = ebo; e.ov = eov;
            q.push_back(e);
        end
        cnt = 0;
        busy_cycles = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                a = ~ta; b = ~tb_;
            end
            if (busy) busy_cycles++;
            if (cnt == 2) check("diff_hold_during_run", diff, hold);
            if (inj_at > 0 && cnt == inj_at) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end
            if (inj_at > 0 && cnt == inj_at + 1) start = 1'b0;
            if (rst_at > 0 && cnt == rst_at) rst = 1'b1;
            if (rst_at > 0 && cnt == rst_at + 1) begin
                rst = 1'b0;
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_diff", diff, '0);
                check("rst_borrow", borrow_out, 1'b0);
                check("rst_overflow", overflow, 1'b0);
                held_diff = '0;
                break;
            end
            if (done) begin
                check("latency", cnt, W + 1);
                check("busy_cycles", busy_cycles, W);
                break;
            end
            if (cnt > 40) begin
                check("done_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int t[3];
        int n;
        exp_t e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_diff", diff, '0);
        check("reset_borrow", borrow_out, 1'b0);
        check("reset_overflow", overflow, 1'b0);

        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0, 0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0, 0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 0);
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, 0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0);
        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 3, 0);
        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0, 4);
        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0, 0);

        // Back-to-back: start held high for three operations.
        @(negedge clk);
        a = 8'hA0; b = 8'h21; b_in = 1'b0;
        e.diff = 8'h7F; e.bo = 1'b0; e.ov = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back(e);
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 80 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        check("b2b_count", n, 3);
        if (n == 3) begin
            check("b2b_period_1", t[1] - t[0], W + 2);
            check("b2b_period_2", t[2] - t[1], W + 2);
        end
        repeat (15) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        check("idle_after_b2b", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
